// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states,
// byte-lane enable and store-data replication helpers.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        ERR
    } state_t;

    // Misaligned low bits are simply dropped here; trapping them is the caller's job.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] adr_lo);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << adr_lo;
            SIZE_H:  be = 4'b0011 << {adr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SIZE_B:  rep = {4{data[7:0]}};
            SIZE_H:  rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port RAM, synchronous read, whole-word write. The read register holds
// its value while the port is idle or writing, so it doubles as the captured word.
module dmem_sram #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, read-modify-write for
// sub-word stores. Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DEPTH_WORDS = 16384,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h4000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_adr_i,
    input  logic [1:0]        req_size_i,
    input  logic [31:0]       req_wd_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o
);

    localparam int unsigned RAM_AW = $clog2(DEPTH_WORDS);

    state_t state, state_next;

    logic [ADDR_W:0]   adr_diff;
    logic [ADDR_W-3:0] word_off;
    logic              out_of_range;
    logic              misaligned;
    logic              req_err;
    logic              accept;
    logic              unused_diff_lsbs;

    logic              we_q;
    logic [1:0]        size_q;
    logic [31:0]       wd_q;
    logic [3:0]        be_q;
    logic [RAM_AW-1:0] idx_q;

    logic              ram_en;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic [31:0]       merged;
    logic [31:0]       store_rep;

    // One extra bit so addresses below the base show up as a borrow.
    assign adr_diff         = {1'b0, req_adr_i} - {1'b0, BASE_ADDR};
    assign word_off         = adr_diff[ADDR_W-1:2];
    assign unused_diff_lsbs = ^adr_diff[1:0];
    assign out_of_range     = adr_diff[ADDR_W] || (32'(word_off) >= DEPTH_WORDS);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = ((req_size_i == SIZE_H) && req_adr_i[0]) ||
                        ((req_size_i == SIZE_W) && (req_adr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_err = out_of_range || (req_size_i == 2'b10) || misaligned;
    assign accept  = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            we_q   <= 1'b0;
            size_q <= 2'b00;
            wd_q   <= '0;
            be_q   <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            we_q   <= req_we_i;
            size_q <= req_size_i;
            wd_q   <= req_wd_i;
            be_q   <= byte_enable(req_size_i, req_adr_i[1:0]);
            idx_q  <= word_off[RAM_AW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_err) begin
                        state_next = ERR;
                    end else if (req_we_i && (req_size_i == SIZE_W)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = we_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Enabled lanes take the store data; the rest keep the word read in READ.
    assign store_rep = replicate(size_q, wd_q);

    always_comb begin
        merged = ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = store_rep[8*i +: 8];
            end
        end
    end

    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        resp_rdata_o = '0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        case (state)
            IDLE: req_ready_o = 1'b1;
            READ: ram_en = 1'b1;
            WRITE: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_rdata_o = we_q ? 32'h0 : ram_rdata;
            end
            ERR: begin
                resp_valid_o = 1'b1;
                resp_err_o   = 1'b1;
            end
            default: ;
        endcase
    end

    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (RAM_AW)
    ) u_sram (
        .clk  (clk_i),
        .en   (ram_en),
        .we   (ram_we),
        .addr (idx_q),
        .wdata(merged),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: latencies, merges, errors, reset abort
// and continuous-valid back-to-back loads.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk_i;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [15:0] req_adr_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_wd_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    int checks   = 0;
    int failures = 0;

    dmem_responder dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_adr_i   (req_adr_i),
        .req_size_i  (req_size_i),
        .req_wd_i    (req_wd_i),
        .resp_valid_o(resp_valid_o),
        .resp_rdata_o(resp_rdata_o),
        .resp_err_o  (resp_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Issues one request and reports the response; latency counts cycles after
    // the accept edge (0 = no response, -1 = never ready). Fields are scrambled
    // after the accept edge to prove the DUT latched them.
    task automatic apply_stimulus(input logic we, input logic [15:0] adr, input logic [1:0] size,
                                  input logic [31:0] wd, output logic [31:0] rdata,
                                  output logic err, output int latency, output logic held);
        int w;
        rdata   = 32'h0;
        err     = 1'b0;
        latency = 0;
        held    = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_adr_i   = adr;
        req_size_i  = size;
        req_wd_i    = wd;
        w = 0;
        while (!req_ready_o && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        if (!req_ready_o) begin
            req_valid_i = 1'b0;
            latency = -1;
            return;
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = ~we;
        req_adr_i   = 16'h0000;
        req_size_i  = 2'b10;
        req_wd_i    = ~wd;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            if (resp_valid_o) begin
                latency = c;
                rdata   = resp_rdata_o;
                err     = resp_err_o;
                break;
            end
        end
        if (latency > 0) begin
            @(negedge clk_i);
            held = resp_valid_o;
        end
    endtask

    task automatic test_reset();
        reset_i     = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_adr_i   = '0;
        req_size_i  = SIZE_W;
        req_wd_i    = '0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b expected 1", req_ready_o);
        end
        checks++;
        if (resp_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid: got %b expected 0", resp_valid_o);
        end
        checks++;
        if (resp_rdata_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata: got %h expected 00000000", resp_rdata_o);
        end
        checks++;
        if (resp_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_err: got %b expected 0", resp_err_o);
        end
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd;
        logic        er;
        logic        hd;
        int          lat;
        apply_stimulus(1'b1, 16'h4000, SIZE_W, 32'hDEADBEEF, rd, er, lat, hd);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || hd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL word_store: lat=%0d err=%b rdata=%h held=%b expected lat=2 err=0 rdata=0 held=0", lat, er, rd, hd);
        end
        apply_stimulus(1'b0, 16'h4000, SIZE_W, 32'h0, rd, er, lat, hd);
        checks++;
        if (lat !== 2 || er !== 1'b0 || hd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL word_load_timing: lat=%0d err=%b held=%b expected lat=2 err=0 held=0", lat, er, hd);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL word_load_data: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd;
        logic        er;
        logic        hd;
        int          lat;
        apply_stimulus(1'b1, 16'h4001, SIZE_B, 32'h0000005A, rd, er, lat, hd);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'h0 || hd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL byte_store: lat=%0d err=%b rdata=%h held=%b expected lat=3 err=0 rdata=0 held=0", lat, er, rd, hd);
        end
        apply_stimulus(1'b0, 16'h4000, SIZE_W, 32'h0, rd, er, lat, hd);
        checks++;
        if (rd !== 32'hDEAD5AEF) begin
            failures++;
            $display("[TB] FAIL byte_merge: got %h expected dead5aef", rd);
        end
        apply_stimulus(1'b1, 16'h4002, SIZE_H, 32'hFFFF1234, rd, er, lat, hd);
        checks++;
        if (lat !== 3 || er !== 1'b0) begin
            failures++;
            $display("[TB] FAIL half_store: lat=%0d err=%b expected lat=3 err=0", lat, er);
        end
        apply_stimulus(1'b0, 16'h4000, SIZE_B, 32'h0, rd, er, lat, hd);
        checks++;
        if (rd !== 32'h12345AEF) begin
            failures++;
            $display("[TB] FAIL half_merge: got %h expected 12345aef", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        logic        hd;
        int          lat;
        apply_stimulus(1'b0, 16'h3FFC, SIZE_W, 32'h0, rd, er, lat, hd);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || hd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL range_err: lat=%0d err=%b rdata=%h held=%b expected lat=1 err=1 rdata=0 held=0", lat, er, rd, hd);
        end
        apply_stimulus(1'b1, 16'h4000, 2'b10, 32'hFFFFFFFF, rd, er, lat, hd);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL size_err: lat=%0d err=%b rdata=%h expected lat=1 err=1 rdata=0", lat, er, rd);
        end
        apply_stimulus(1'b0, 16'h4000, SIZE_W, 32'h0, rd, er, lat, hd);
        checks++;
        if (rd !== 32'h12345AEF) begin
            failures++;
            $display("[TB] FAIL err_no_write: got %h expected 12345aef", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er;
        logic        hd;
        int          lat;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_word;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_err  = 1'b1;
        exp_lat  = 1;
        exp_word = 32'h0BADF00D;
`else
        exp_err  = 1'b0;
        exp_lat  = 2;
        exp_word = 32'hCAFEF00D;
`endif
        apply_stimulus(1'b1, 16'h4004, SIZE_W, 32'h0BADF00D, rd, er, lat, hd);
        apply_stimulus(1'b1, 16'h4006, SIZE_W, 32'hCAFEF00D, rd, er, lat, hd);
        checks++;
        if (lat !== exp_lat || er !== exp_err) begin
            failures++;
            $display("[TB] FAIL misalign_resp: lat=%0d err=%b expected lat=%0d err=%b", lat, er, exp_lat, exp_err);
        end
        apply_stimulus(1'b0, 16'h4004, SIZE_W, 32'h0, rd, er, lat, hd);
        checks++;
        if (rd !== exp_word) begin
            failures++;
            $display("[TB] FAIL misalign_word: got %h expected %h", rd, exp_word);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic        er;
        logic        hd;
        int          lat;
        logic        saw_resp;
        apply_stimulus(1'b1, 16'h4008, SIZE_W, 32'h11111111, rd, er, lat, hd);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_adr_i   = 16'h4008;
        req_size_i  = SIZE_B;
        req_wd_i    = 32'h000000FF;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_busy: ready got %b expected 0", req_ready_o);
        end
        @(negedge clk_i);
        reset_i  = 1'b0;
        saw_resp = 1'b0;
        #1;
        if (resp_valid_o) saw_resp = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            if (resp_valid_o) saw_resp = 1'b1;
        end
        reset_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            if (resp_valid_o) saw_resp = 1'b1;
        end
        checks++;
        if (saw_resp !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_state: resp_seen=%b ready=%b expected resp_seen=0 ready=1", saw_resp, req_ready_o);
        end
        apply_stimulus(1'b0, 16'h4008, SIZE_W, 32'h0, rd, er, lat, hd);
        checks++;
        if (rd !== 32'h11111111) begin
            failures++;
            $display("[TB] FAIL abort_no_write: got %h expected 11111111", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        logic        hd;
        int          lat;
        logic [15:0] adrs [3];
        logic [31:0] words [3];
        logic [31:0] got_data [3];
        int          acc_cyc [3];
        int          sent;
        int          got;
        int          overlap;
        int          cyc;
        logic        will;
        adrs  = '{16'h4010, 16'h4014, 16'h4018};
        words = '{32'hA0A0A0A1, 32'hB0B0B0B2, 32'hC0C0C0C3};
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, adrs[i], SIZE_W, words[i], rd, er, lat, hd);
            got_data[i] = 32'h0;
            acc_cyc[i]  = -1;
        end
        sent    = 0;
        got     = 0;
        overlap = 0;
        cyc     = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_size_i  = SIZE_W;
        req_adr_i   = adrs[0];
        while ((sent < 3 || got < 3) && cyc < 40) begin
            if (resp_valid_o) begin
                if (got < 3) got_data[got] = resp_rdata_o;
                got++;
                if (req_ready_o) overlap++;
            end
            will = req_valid_i && req_ready_o;
            if (will && sent < 3) acc_cyc[sent] = cyc;
            @(posedge clk_i);
            #1;
            if (will) begin
                sent++;
                if (sent < 3) req_adr_i = adrs[sent];
                else req_valid_i = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        req_valid_i = 1'b0;
        repeat (4) begin
            if (resp_valid_o) got++;
            @(negedge clk_i);
        end
        checks++;
        if (sent !== 3 || got !== 3 || overlap !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_counts: sent=%0d resp=%0d overlap=%0d expected 3 3 0", sent, got, overlap);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_data[i] !== words[i]) begin
                failures++;
                $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, got_data[i], words[i]);
            end
        end
        checks++;
        if (acc_cyc[0] !== 0 || acc_cyc[1] !== 3 || acc_cyc[2] !== 6) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: accepts at %0d %0d %0d expected 0 3 6", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_errors();
        test_misalign();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
